// File: rtl/ula_subarray_scheduler.sv
// ULA subarray scheduler: forwards a configured window of array elements for a
// fixed number of snapshots, checks snapshot alignment and reports completion.
module ula_subarray_scheduler #(
   parameter int unsigned N_ANT  = 8,
   parameter int unsigned DATA_W = 32,
   parameter int unsigned SNAP_W = 16,
   localparam int unsigned ANT_W = $clog2(N_ANT)
) (
   input  logic              ap_clk,
   input  logic              ap_rst,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic [ANT_W-1:0]  cfg_start,
   input  logic [ANT_W:0]    cfg_len,
   input  logic [SNAP_W-1:0] cfg_snaps,
   input  logic [DATA_W-1:0] in_stream_TDATA,
   input  logic              in_stream_TVALID,
   input  logic              in_stream_TLAST,
   output logic              in_stream_TREADY,
   output logic [DATA_W-1:0] out_stream_TDATA,
   output logic              out_stream_TVALID,
   output logic              out_stream_TLAST,
   input  logic              out_stream_TREADY,
   output logic              busy,
   output logic              frame_done,
   output logic              cfg_err,
   output logic              sync_err
);

   localparam int unsigned SUM_W = ANT_W + 2;
   localparam logic [ANT_W-1:0] ANT_LAST = ANT_W'(N_ANT - 1);

   typedef enum logic [1:0] {IDLE, RUN, TAIL, DONE} state_t;

   state_t            state, state_nxt;
   logic [ANT_W-1:0]  start_q, end_q;
   logic [SNAP_W-1:0] snap_last_q;
   logic [ANT_W-1:0]  ant_idx;
   logic [SNAP_W-1:0] snap_idx;
   logic [DATA_W-1:0] data_q;
   logic              valid_q, last_q;
   logic              frame_done_q, cfg_err_q, sync_err_q;

   logic [SUM_W-1:0]  cfg_sum;
   logic              cfg_legal, cfg_take, cfg_reject;
   logic              accept, at_last_ant, selected, final_beat;
   logic              load, finish;

   // Config legality: non-empty window fitting inside the array, at least one snapshot
   assign cfg_sum   = SUM_W'(cfg_start) + SUM_W'(cfg_len);
   assign cfg_legal = (cfg_len != '0) && (cfg_snaps != '0) && (cfg_sum <= SUM_W'(N_ANT));

   assign in_stream_TREADY = ((state == RUN) && (!valid_q || out_stream_TREADY)) || (state == TAIL);
   assign accept      = in_stream_TVALID && in_stream_TREADY;
   assign at_last_ant = (ant_idx == ANT_LAST);
   assign selected    = (ant_idx >= start_q) && (ant_idx <= end_q);
   assign final_beat  = (ant_idx == end_q) && (snap_idx == snap_last_q);

   assign cfg_ready         = (state == IDLE);
   assign busy              = (state != IDLE);
   assign out_stream_TDATA  = data_q;
   assign out_stream_TVALID = valid_q;
   assign out_stream_TLAST  = last_q;
   assign frame_done        = frame_done_q;
   assign cfg_err           = cfg_err_q;
   assign sync_err          = sync_err_q;

   always_comb begin
      state_nxt  = state;
      cfg_take   = 1'b0;
      cfg_reject = 1'b0;
      load       = 1'b0;
      finish     = 1'b0;
      case (state)
         IDLE: begin
            if (cfg_valid) begin
               if (cfg_legal) begin
                  cfg_take  = 1'b1;
                  state_nxt = RUN;
               end else begin
                  cfg_reject = 1'b1;
               end
            end
         end
         RUN: begin
            if (accept) begin
               load = selected;
               if (final_beat)
                  state_nxt = (end_q == ANT_LAST) ? DONE : TAIL;
            end
         end
         TAIL: begin
            // Drain the rest of the last snapshot so the next frame starts aligned
            if (accept && at_last_ant)
               state_nxt = DONE;
         end
         DONE: begin
            if (!valid_q || out_stream_TREADY) begin
               finish    = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         state        <= IDLE;
         start_q      <= '0;
         end_q        <= '0;
         snap_last_q  <= '0;
         ant_idx      <= '0;
         snap_idx     <= '0;
         data_q       <= '0;
         valid_q      <= 1'b0;
         last_q       <= 1'b0;
         frame_done_q <= 1'b0;
         cfg_err_q    <= 1'b0;
         sync_err_q   <= 1'b0;
      end else begin
         state        <= state_nxt;
         frame_done_q <= finish;
         cfg_err_q    <= cfg_reject;

         if (cfg_take) begin
            start_q     <= cfg_start;
            end_q       <= ANT_W'(cfg_sum - SUM_W'(1));
            snap_last_q <= cfg_snaps - SNAP_W'(1);
            ant_idx     <= '0;
            snap_idx    <= '0;
            sync_err_q  <= 1'b0;
         end else if (accept) begin
            // Early TLAST restarts the snapshot; missing TLAST still wraps
            if (in_stream_TLAST && !at_last_ant) begin
               sync_err_q <= 1'b1;
               ant_idx    <= '0;
            end else if (at_last_ant) begin
               ant_idx  <= '0;
               snap_idx <= snap_idx + SNAP_W'(1);
               if (!in_stream_TLAST)
                  sync_err_q <= 1'b1;
            end else begin
               ant_idx <= ant_idx + ANT_W'(1);
            end
         end

         if (load) begin
            data_q  <= in_stream_TDATA;
            valid_q <= 1'b1;
            last_q  <= final_beat;
         end else if (out_stream_TREADY) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
         end
      end
   end

endmodule
